// File: rtl/adc_stream_framer.sv
// rtl/adc_stream_framer.sv - Frames bytes drained from the ADC FIFO as sync, length, payload, checksum.
// Optional FRAMER_CRC8_EN replaces the additive checksum with CRC-8 (poly 0x07) over the payload.
module adc_stream_framer #(
    parameter int          LEN_W       = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAC,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_rd_en_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o,
    output logic [LEN_W-1:0] bytes_left_o
);

    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, SYNC, LENH, LENL, PL_RD, PL_WAIT, PL_SEND, CSUM, FIN
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] remaining;
    logic [15:0]      len_hdr;
    logic [7:0]       csum;
    logic [7:0]       hold;
    logic [TW-1:0]    tmo_cnt;
    logic             underrun;
    logic             tx_fire;
    logic             tmo_hit;

    function automatic logic [7:0] csum_next(input logic [7:0] c, input logic [7:0] b);
`ifdef FRAMER_CRC8_EN
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
`else
        return c + b;
`endif
    endfunction

    assign tx_fire      = tx_valid_o && tx_ready_i;
    assign tmo_hit      = fifo_empty_i && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign underrun_o   = underrun;
    assign bytes_left_o = remaining;

    always_comb begin
        state_nx     = state;
        tx_valid_o   = 1'b0;
        tx_data_o    = 8'h00;
        fifo_rd_en_o = 1'b0;
        busy_o       = (state != IDLE);
        done_o       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nx = SYNC;
            end
            SYNC: begin
                tx_valid_o = 1'b1;
                tx_data_o  = SYNC_BYTE;
                if (tx_fire) state_nx = LENH;
            end
            LENH: begin
                tx_valid_o = 1'b1;
                tx_data_o  = len_hdr[15:8];
                if (tx_fire) state_nx = LENL;
            end
            LENL: begin
                tx_valid_o = 1'b1;
                tx_data_o  = len_hdr[7:0];
                if (tx_fire) state_nx = (remaining == '0) ? CSUM : PL_RD;
            end
            PL_RD: begin
                // Once underrun, the FIFO is left alone and the payload is padded with zeros.
                if (underrun) begin
                    state_nx = PL_SEND;
                end else if (!fifo_empty_i) begin
                    fifo_rd_en_o = 1'b1;
                    state_nx     = PL_WAIT;
                end else if (tmo_hit) begin
                    state_nx = PL_SEND;
                end
            end
            PL_WAIT: begin
                state_nx = PL_SEND;
            end
            PL_SEND: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hold;
                if (tx_fire) state_nx = (remaining == LEN_W'(1)) ? CSUM : PL_RD;
            end
            CSUM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = csum;
                if (tx_fire) state_nx = FIN;
            end
            FIN: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            remaining <= '0;
            len_hdr   <= '0;
            csum      <= '0;
            hold      <= '0;
            tmo_cnt   <= '0;
            underrun  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        remaining <= len_i;
                        len_hdr   <= 16'(len_i);
                        csum      <= '0;
                        tmo_cnt   <= '0;
                        underrun  <= 1'b0;
                    end
                end
                PL_RD: begin
                    if (underrun) begin
                        hold <= 8'h00;
                    end else if (!fifo_empty_i) begin
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        underrun <= 1'b1;
                        hold     <= 8'h00;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                PL_WAIT: hold <= fifo_data_i;
                PL_SEND: begin
                    if (tx_fire) begin
                        csum      <= csum_next(csum, hold);
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
